dma_stream_unpacker: RTL and testbench



---
 rtl/dma_stream_unpacker_pkg.sv | 32 +++
 rtl/dma_stream_unpacker_if.sv | 11 +
 rtl/dma_stream_unpacker_slice_mux.sv | 24 ++
 rtl/dma_stream_unpacker.sv | 182 ++++++++++++++++++
 tb/tb_dma_stream_unpacker.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma_stream_unpacker_pkg.sv
// Shared types and elaboration helpers for the DMA stream unpacker.
package dma_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } unpack_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // True when IN/OUT is an integer ratio that is a power of two and at least 2.
  function automatic bit ratio_ok(input int in_w, input int out_w);
    int r;
    if (out_w <= 0) return 1'b0;
    if ((in_w % out_w) != 0) return 1'b0;
    r = in_w / out_w;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/dma_stream_unpacker_if.sv
// Ready/valid handshake bundle; Master drives Valid/Data, Slave drives Ready.
interface ReadyValidIntf #(
  parameter int WIDTH = 16
);
  logic             Valid;
  logic             Ready;
  logic [WIDTH-1:0] Data;

  modport Master (output Valid, output Data, input Ready);
  modport Slave  (input Valid, input Data, output Ready);
endinterface

// File: rtl/dma_stream_unpacker_slice_mux.sv
// Combinational selector of one OUT_WIDTH slice out of a wide word.
module dma_slice_mux #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int SUB_WIDTH = 2
) (
  input  logic [IN_WIDTH-1:0]  word_i,
  input  logic [SUB_WIDTH-1:0] sub_i,
  output logic [OUT_WIDTH-1:0] slice_o
);
  localparam int R = IN_WIDTH / OUT_WIDTH;

  logic [OUT_WIDTH-1:0] slices [R];

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_slice
      assign slices[gi] = word_i[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  // R is a power of two, so sub_i spans exactly the slice array.
  assign slice_o = slices[sub_i];
endmodule

// File: rtl/dma_stream_unpacker.sv
// Wide-word to narrow-beat unpacker between a queue dequeue port and a beat sink.
// Optional feature macro: DMA_UNPACK_PREFETCH_EN (back-to-back word reload, 1 beat/cycle).
module dma_stream_unpacker
  import dma_unpack_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 Abort,
  input  logic                 Start,
  input  logic [LEN_WIDTH-1:0] Length,
  output logic                 Busy,
  output logic                 Done,
  ReadyValidIntf.Slave         InIntf,
  ReadyValidIntf.Master        OutIntf
);
  localparam int R         = IN_WIDTH / OUT_WIDTH;
  localparam int SUB_WIDTH = clog2(R);
  localparam logic [SUB_WIDTH-1:0] SUB_LAST = SUB_WIDTH'(R - 1);

  generate
    if (!ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
      $error("dma_stream_unpacker: IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
    end
  endgenerate

  unpack_state_e          state_q, state_d;
  logic [IN_WIDTH-1:0]    word_q, word_d;
  logic [SUB_WIDTH-1:0]   sub_q, sub_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   done_q, done_d;

  logic                   in_ready;
  logic                   out_valid;
  logic                   busy;
  logic                   in_hs;
  logic                   out_hs;
  logic                   last_slice;
  logic                   last_beat;
  logic [OUT_WIDTH-1:0]   slice;

  assign in_hs      = InIntf.Valid & in_ready;
  assign out_hs     = out_valid & OutIntf.Ready;
  assign last_slice = (sub_q == SUB_LAST);
  assign last_beat  = (remaining_q == LEN_WIDTH'(1));

  dma_slice_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SUB_WIDTH (SUB_WIDTH)
  ) u_slice_mux (
    .word_i  (word_q),
    .sub_i   (sub_q),
    .slice_o (slice)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Abort overrides every other condition.
  always_comb begin
    state_d = state_q;
    if (Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (Start && (Length != '0)) state_d = LOAD;
        LOAD: if (in_hs) state_d = EMIT;
        EMIT: begin
          if (out_hs) begin
            if (last_beat) begin
              state_d = IDLE;
            end else if (last_slice) begin
`ifdef DMA_UNPACK_PREFETCH_EN
              // A reload in the same cycle keeps us emitting without a bubble.
              if (!in_hs) state_d = LOAD;
`else
              state_d = LOAD;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
`ifdef DMA_UNPACK_PREFETCH_EN
        // Only pull the next word when the current last slice is leaving and more beats remain.
        if (last_slice && !last_beat) in_ready = OutIntf.Ready;
`endif
      end
      default: ;
    endcase
  end

  // Datapath next values: word capture, slice index, beat counter and Done pulse.
  always_comb begin
    word_d      = word_q;
    sub_d       = sub_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (Abort) begin
      // A word handshaked in this cycle is dropped on purpose.
      sub_d       = '0;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (Length != '0) remaining_d = Length;
            else              done_d      = 1'b1;
          end
        end
        LOAD: begin
          if (in_hs) begin
            word_d = InIntf.Data;
            sub_d  = '0;
          end
        end
        EMIT: begin
          if (out_hs) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
            sub_d       = sub_q + SUB_WIDTH'(1);
            if (last_beat) done_d = 1'b1;
          end
`ifdef DMA_UNPACK_PREFETCH_EN
          if (in_hs) begin
            word_d = InIntf.Data;
            sub_d  = '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      word_q      <= '0;
      sub_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      word_q      <= word_d;
      sub_q       <= sub_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign InIntf.Ready  = in_ready;
  assign OutIntf.Valid = out_valid;
  assign OutIntf.Data  = slice;
  assign Busy          = busy;
  assign Done          = done_q;

endmodule

// File: tb/tb_dma_stream_unpacker.sv
// Directed, table-driven bench for dma_stream_unpacker (IN=64, OUT=16).
module tb_dma_stream_unpacker;

`ifdef DMA_UNPACK_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  localparam logic [63:0] WA = 64'h4444_3333_2222_1111;
  localparam logic [63:0] WB = 64'hA003_A002_A001_A000;
  localparam logic [63:0] WC = 64'hB003_B002_B001_B000;
  localparam logic [63:0] WD = 64'hC003_C002_C001_C000;
  localparam logic [63:0] WE = 64'hD003_D002_D001_D000;
  localparam logic [63:0] WF = 64'hE003_E002_E001_E000;

  logic        ACLK;
  logic        ARESETn;
  logic        abort_s;
  logic        start_s;
  logic [15:0] length_s;
  logic        Busy;
  logic        Done;

  ReadyValidIntf #(.WIDTH(64)) in_if ();
  ReadyValidIntf #(.WIDTH(16)) out_if ();

  dma_stream_unpacker #(
    .IN_WIDTH  (64),
    .OUT_WIDTH (16),
    .LEN_WIDTH (16)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .Abort   (abort_s),
    .Start   (start_s),
    .Length  (length_s),
    .Busy    (Busy),
    .Done    (Done),
    .InIntf  (in_if),
    .OutIntf (out_if)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        ab;
    logic        st;
    logic [15:0] len;
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        busy;
    logic        done;
    logic        ir;
    logic        ov;
    logic [15:0] od;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ab, input logic st, input logic [15:0] len,
                              input logic iv, input logic [63:0] id, input logic ordy,
                              input logic busy, input logic done, input logic ir,
                              input logic ov, input logic [15:0] od);
    vec_t v;
    v.ab = ab; v.st = st; v.len = len; v.iv = iv; v.id = id; v.ordy = ordy;
    v.busy = busy; v.done = done; v.ir = ir; v.ov = ov; v.od = od;
    return v;
  endfunction

  task automatic build_table();
    // basic run, Length=4
    vq.push_back(mk(0,1,4,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,1,WA,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'h1111));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'h2222));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'h3333));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'h4444));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,1,0,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,0,0,0,16'h0));
    // partial word, Length=6
    vq.push_back(mk(0,1,6,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,1,WB,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hA000));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hA001));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hA002));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,PF,1,16'hA003));
    vq.push_back(mk(0,0,0,1,WC,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hB000));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hB001));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,1,0,0,16'h0));
    // backpressure 1-0-0-1
    vq.push_back(mk(0,1,4,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,1,WD,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hC000));
    vq.push_back(mk(0,0,0,0,0 ,0, 1,0,0,1,16'hC001));
    vq.push_back(mk(0,0,0,0,0 ,0, 1,0,0,1,16'hC001));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hC001));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hC002));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hC003));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,1,0,0,16'h0));
    // zero length
    vq.push_back(mk(0,1,0,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,1,0,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,0,0,0,16'h0));
    // abort after beat 2 of 8
    vq.push_back(mk(0,1,8,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,1,WE,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hD000));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hD001));
    vq.push_back(mk(1,0,0,0,0 ,0, 1,0,0,1,16'hD002));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,0,0,0,16'h0));
    // clean restart, Length=4, then Start during the Done cycle
    vq.push_back(mk(0,1,4,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,1,WF,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hE000));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hE001));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hE002));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hE003));
    vq.push_back(mk(0,1,2,0,0 ,1, 0,1,0,0,16'h0));
    vq.push_back(mk(0,0,0,1,WF,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hE000));
    vq.push_back(mk(0,0,0,0,0 ,1, 1,0,0,1,16'hE001));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,1,0,0,16'h0));
    // abort coinciding with an input handshake: word dropped, no EMIT
    vq.push_back(mk(0,1,4,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(1,0,0,1,WA,1, 1,0,1,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,0,0,0,16'h0));
    vq.push_back(mk(0,0,0,0,0 ,1, 0,0,0,0,16'h0));
  endtask

  // Length=8 with input always valid and sink always ready.
  task automatic run_throughput();
    logic [63:0] w5;
    logic [63:0] w6;
    logic [63:0] wexp;
    int          beat;
    int          hs;
    int          done_cyc;
    int          exp_cyc;
    logic        hs_now;
    w5 = 64'h5003_5002_5001_5000;
    w6 = 64'h6003_6002_6001_6000;
    beat = 0; hs = 0; done_cyc = -1;
    start_s = 1'b1; length_s = 16'd8;
    in_if.Valid = 1'b1; in_if.Data = w5; out_if.Ready = 1'b1;
    for (int c = 0; c < 30 && done_cyc < 0; c++) begin
      @(negedge ACLK);
      hs_now = in_if.Valid && in_if.Ready;
      if (hs_now) hs++;
      if (out_if.Valid && out_if.Ready) begin
        wexp = (beat < 4) ? w5 : w6;
        exp_cyc = (PF || beat < 4) ? (2 + beat) : (3 + beat);
        chk($sformatf("tp_data%0d", beat), 64'(out_if.Data), 64'(wexp[(beat % 4)*16 +: 16]));
        chk($sformatf("tp_cycle%0d", beat), 64'(c), 64'(exp_cyc));
        if (beat == 3) chk("tp_ready_beat4", 64'(in_if.Ready), 64'(PF));
        beat++;
      end
      if (Done) done_cyc = c;
      @(posedge ACLK);
      #1;
      start_s = 1'b0;
      if (hs_now) in_if.Data = w6;
    end
    chk("tp_beats", 64'(beat), 64'd8);
    chk("tp_in_hs", 64'(hs), 64'd2);
    chk("tp_done_cycle", 64'(done_cyc), PF ? 64'd10 : 64'd11);
    in_if.Valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    ARESETn = 1'b0; abort_s = 1'b0; start_s = 1'b0; length_s = '0;
    in_if.Valid = 1'b0; in_if.Data = '0; out_if.Ready = 1'b0;
    build_table();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_busy",  64'(Busy), 64'd0);
    chk("rst_done",  64'(Done), 64'd0);
    chk("rst_ready", 64'(in_if.Ready), 64'd0);
    chk("rst_valid", 64'(out_if.Valid), 64'd0);
    chk("rst_data",  64'(out_if.Data), 64'd0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      abort_s = vq[i].ab; start_s = vq[i].st; length_s = vq[i].len;
      in_if.Valid = vq[i].iv; in_if.Data = vq[i].id; out_if.Ready = vq[i].ordy;
      @(negedge ACLK);
      chk($sformatf("v%0d_busy", i),  64'(Busy),          64'(vq[i].busy));
      chk($sformatf("v%0d_done", i),  64'(Done),          64'(vq[i].done));
      chk($sformatf("v%0d_inrdy", i), 64'(in_if.Ready),   64'(vq[i].ir));
      chk($sformatf("v%0d_valid", i), 64'(out_if.Valid),  64'(vq[i].ov));
      if (vq[i].ov) chk($sformatf("v%0d_data", i), 64'(out_if.Data), 64'(vq[i].od));
      $display("vec %0d: st=%0b len=%0d ab=%0b iv=%0b ordy=%0b -> busy=%0b done=%0b ir=%0b ov=%0b od=%h",
               i, vq[i].st, vq[i].len, vq[i].ab, vq[i].iv, vq[i].ordy,
               Busy, Done, in_if.Ready, out_if.Valid, out_if.Data);
      @(posedge ACLK);
      #1;
    end
    abort_s = 1'b0; start_s = 1'b0; in_if.Valid = 1'b0; out_if.Ready = 1'b0;
    @(posedge ACLK);
    #1;

    run_throughput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
